// File: rtl/fp_normalize_round.sv
// -----------------------------------------------------------------------------
// fp_normalize_round
//
// Final stage of the FP add/sub pipe. Takes the aligned, summed significand of
// each lane (with carry-out, guard, round and sticky), normalises it, rounds to
// nearest-even, and packs an IEEE-754 single result. NaN, infinity, zero,
// overflow and underflow are resolved here. The output feeds the writeback mux.
//
// Pipeline: two free-running register stages with a fixed 2-cycle latency and
// no backpressure. A memory-pipeline rollback squashes the valid bit of
// whichever stage holds the rolled-back thread; other threads pass through.
//
// Build option:
//   FP_DENORMAL_EN  defined   -> underflowing results become gradual denormals
//                   undefined -> underflowing results flush to signed zero
//
// Ports:
//   clk, reset                 clock; asynchronous active-high reset
//   rollback_en                rollback request this cycle
//   rollback_thread_idx        thread being rolled back
//   rollback_mem               rollback originates from the memory pipeline
//   in_valid                   input beat valid
//   in_thread_idx              issuing thread
//   in_mask                    active lanes
//   in_sum[l]                  bit24 = carry-out, bit23 = hidden-bit position
//   in_guard/round/sticky[l]   bits below in_sum[l][0]
//   in_exponent[l]             biased exponent of the larger operand
//   in_sign[l]                 result sign
//   in_is_inf/in_is_nan[l]     special-case overrides
//   out_valid                  result beat valid
//   out_thread_idx             thread of the result
//   out_mask                   lane mask of the result
//   out_result[l]              packed float per lane (0 for inactive lanes)
// -----------------------------------------------------------------------------
module fp_normalize_round #(
  parameter int unsigned LANES        = 16,
  parameter int unsigned THREAD_IDX_W = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          rollback_en,
  input  logic [THREAD_IDX_W-1:0]       rollback_thread_idx,
  input  logic                          rollback_mem,
  input  logic                          in_valid,
  input  logic [THREAD_IDX_W-1:0]       in_thread_idx,
  input  logic [LANES-1:0]              in_mask,
  input  logic [LANES-1:0][24:0]        in_sum,
  input  logic [LANES-1:0]              in_guard,
  input  logic [LANES-1:0]              in_round,
  input  logic [LANES-1:0]              in_sticky,
  input  logic [LANES-1:0][7:0]         in_exponent,
  input  logic [LANES-1:0]              in_sign,
  input  logic [LANES-1:0]              in_is_inf,
  input  logic [LANES-1:0]              in_is_nan,
  output logic                          out_valid,
  output logic [THREAD_IDX_W-1:0]       out_thread_idx,
  output logic [LANES-1:0]              out_mask,
  output logic [LANES-1:0][31:0]        out_result
);

  // Per-lane state carried from stage 1 to stage 2.
  typedef struct packed {
    logic [24:0] sum;
    logic        guard;
    logic        round;
    logic        sticky;
    logic        sign;
    logic        is_nan;
    logic        is_inf;
    logic        is_zero;
    logic        under;
    logic [4:0]  shift;   // left shift applied on the non-carry path
    logic [9:0]  exp;     // two's-complement target exponent
  } s1_lane_t;

  // Leading zeros of a 24-bit significand; 24 when it is all zero.
  function automatic logic [4:0] lzc24(input logic [23:0] v);
    logic [4:0] n;
    n = 5'd24;
    for (int unsigned b = 0; b < 24; b++) begin
      if (v[b]) n = 5'(23 - b);
    end
    return n;
  endfunction

  // Stage 1: classify the lane and work out how far it must move.
  function automatic s1_lane_t stage1(
    input logic [24:0] sum,
    input logic        guard,
    input logic        round,
    input logic        sticky,
    input logic        sign,
    input logic        is_nan,
    input logic        is_inf,
    input logic [7:0]  exponent
  );
    s1_lane_t   l;
    logic [4:0] lz;
    logic [9:0] exp_lz;

    lz        = lzc24(sum[23:0]);
    exp_lz    = {2'b00, exponent} - {5'd0, lz};

    l.sum     = sum;
    l.guard   = guard;
    l.round   = round;
    l.sticky  = sticky;
    l.sign    = sign;
    l.is_nan  = is_nan;
    l.is_inf  = is_inf;
    l.is_zero = (sum == 25'd0) && !guard && !round;
    l.under   = !sum[24] && ($signed(exp_lz) < 10'sd1);
    l.exp     = sum[24] ? ({2'b00, exponent} + 10'd1) : exp_lz;
    l.shift   = lz;
`ifdef FP_DENORMAL_EN
    // Denormals are only shifted far enough to land at exponent field 0.
    // Underflow implies exponent-1 < lz <= 24, so the 5-bit truncation is safe.
    if (l.under) l.shift = (exponent == 8'd0) ? 5'd0 : 5'(exponent - 8'd1);
`endif
    return l;
  endfunction

  // Stage 2: shift, round to nearest-even, resolve specials and pack.
  function automatic logic [31:0] stage2(input s1_lane_t l, input logic active);
    logic [25:0] norm;
    logic [23:0] mant;
    logic        g;
    logic        st;
    logic        up;
    logic [24:0] mant_r;
    logic [9:0]  exp_f;
    logic [31:0] res;

    norm = {l.sum[23:0], l.guard, l.round} << l.shift;

    if (l.sum[24]) begin
      mant = l.sum[24:1];
      g    = l.sum[0];
      st   = l.guard | l.round | l.sticky;
    end else begin
      mant = norm[25:2];
      g    = norm[1];
      st   = norm[0] | l.sticky;
    end

    up     = g & (st | mant[0]);
    mant_r = {1'b0, mant} + {24'd0, up};

    // A normal result that rounds past 0xFFFFFF leaves fraction bits at zero,
    // so only the exponent needs the carry. A denormal sits at field 0 and
    // becomes field 1 once rounding reaches the hidden-bit position.
    exp_f = l.under ? {9'd0, mant_r[23]} : (l.exp + {9'd0, mant_r[24]});

    if (!active)
      res = '0;
    else if (l.is_nan)
      res = 32'h7FFF_FFFF;
    else if (l.is_inf)
      res = {l.sign, 31'h7F80_0000};
    else if (l.is_zero)
      res = '0;
    else if (l.under)
`ifdef FP_DENORMAL_EN
      res = {l.sign, exp_f[7:0], mant_r[22:0]};
`else
      res = {l.sign, 31'd0};
`endif
    else if ($signed(exp_f) >= 10'sd255)
      res = {l.sign, 31'h7F80_0000};
    else
      res = {l.sign, exp_f[7:0], mant_r[22:0]};
    return res;
  endfunction

  // Pipeline state
  logic                    s1_valid;
  logic [THREAD_IDX_W-1:0] s1_thread;
  logic [LANES-1:0]        s1_mask;
  s1_lane_t                s1_q [LANES];
  s1_lane_t                s1_d [LANES];
  logic [LANES-1:0][31:0]  res_d;

  logic rb_hit;
  logic kill_in;
  logic kill_s1;

  assign rb_hit  = rollback_en && rollback_mem;
  assign kill_in = rb_hit && (rollback_thread_idx == in_thread_idx);
  assign kill_s1 = rb_hit && (rollback_thread_idx == s1_thread);

  always_comb begin
    for (int unsigned i = 0; i < LANES; i++) begin
      s1_d[i] = stage1(in_sum[i], in_guard[i], in_round[i], in_sticky[i],
                       in_sign[i], in_is_nan[i], in_is_inf[i], in_exponent[i]);
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < LANES; i++) begin
      res_d[i] = stage2(s1_q[i], s1_mask[i]);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid       <= 1'b0;
      s1_thread      <= '0;
      s1_mask        <= '0;
      for (int unsigned i = 0; i < LANES; i++) s1_q[i] <= '0;
      out_valid      <= 1'b0;
      out_thread_idx <= '0;
      out_mask       <= '0;
      out_result     <= '0;
    end else begin
      s1_valid       <= in_valid && !kill_in;
      s1_thread      <= in_thread_idx;
      s1_mask        <= in_mask;
      for (int unsigned i = 0; i < LANES; i++) s1_q[i] <= s1_d[i];
      out_valid      <= s1_valid && !kill_s1;
      out_thread_idx <= s1_thread;
      out_mask       <= s1_mask;
      out_result     <= res_d;
    end
  end

endmodule

// File: tb/tb_fp_normalize_round.sv
// -----------------------------------------------------------------------------
// tb_fp_normalize_round
//
// Self-checking bench for fp_normalize_round. A per-lane reference function
// computes each packed float from the arithmetic rules (find the leading one,
// scale, round to nearest-even, classify). Every issued beat is logged by
// cycle number; a compare process derives the expected output two cycles
// later, applying rollback squash and reset flushes from that log.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_fp_normalize_round;
  localparam int unsigned LANES = 16;
  localparam int unsigned TW    = 2;
  localparam int unsigned MAXC  = 4096;

`ifdef FP_DENORMAL_EN
  localparam logic [31:0] UF_WANT = 32'h0000_0200;
`else
  localparam logic [31:0] UF_WANT = 32'h0000_0000;
`endif

  typedef longint unsigned u64;

  logic                   clk = 1'b0;
  logic                   reset;
  logic                   rollback_en;
  logic [TW-1:0]          rollback_thread_idx;
  logic                   rollback_mem;
  logic                   in_valid;
  logic [TW-1:0]          in_thread_idx;
  logic [LANES-1:0]       in_mask;
  logic [LANES-1:0][24:0] in_sum;
  logic [LANES-1:0]       in_guard, in_round, in_sticky;
  logic [LANES-1:0][7:0]  in_exponent;
  logic [LANES-1:0]       in_sign, in_is_inf, in_is_nan;
  logic                   out_valid;
  logic [TW-1:0]          out_thread_idx;
  logic [LANES-1:0]       out_mask;
  logic [LANES-1:0][31:0] out_result;

  always #5 clk = ~clk;

  fp_normalize_round #(.LANES(LANES), .THREAD_IDX_W(TW)) dut (
    .clk(clk), .reset(reset),
    .rollback_en(rollback_en), .rollback_thread_idx(rollback_thread_idx),
    .rollback_mem(rollback_mem),
    .in_valid(in_valid), .in_thread_idx(in_thread_idx), .in_mask(in_mask),
    .in_sum(in_sum), .in_guard(in_guard), .in_round(in_round),
    .in_sticky(in_sticky), .in_exponent(in_exponent), .in_sign(in_sign),
    .in_is_inf(in_is_inf), .in_is_nan(in_is_nan),
    .out_valid(out_valid), .out_thread_idx(out_thread_idx),
    .out_mask(out_mask), .out_result(out_result)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  bit chk_on  = 1'b0;

  // Beat log indexed by issue cycle
  bit                     h_valid [MAXC];
  bit                     h_flush [MAXC];
  bit                     h_rb    [MAXC];
  logic [TW-1:0]          h_thr   [MAXC];
  logic [TW-1:0]          h_rbthr [MAXC];
  logic [LANES-1:0]       h_mask  [MAXC];
  logic [LANES-1:0][31:0] h_res   [MAXC];

  // Reference: value = {sum, g, r} scaled by 2^exp, rounded to 24 bits.
  function automatic logic [31:0] ref_lane(
    input logic m, input logic nan, input logic inf, input logic sign,
    input logic [24:0] sum, input logic g, input logic r, input logic s,
    input logic [7:0] ex
  );
    int e, lz, sh;
    u64 w, q;
    bit gb, sb, under;
    if (!m)   return 32'h0;
    if (nan)  return 32'h7FFF_FFFF;
    if (inf)  return {sign, 31'h7F80_0000};
    if (sum == 25'd0 && !g && !r) return 32'h0;
    under = 1'b0;
    if (sum[24]) begin
      e  = int'(ex) + 1;
      q  = u64'(sum) >> 1;
      gb = sum[0];
      sb = g | r | s;
    end else begin
      lz = 0;
      while (lz < 24 && sum[23 - lz] == 1'b0) lz++;
      e     = int'(ex) - lz;
      under = (e < 1);
      sh    = lz;
      if (under) begin
`ifdef FP_DENORMAL_EN
        sh = (ex > 8'd1) ? int'(ex) - 1 : 0;
`else
        return {sign, 31'h0};
`endif
      end
      w  = (u64'({sum[23:0], g, r}) << sh) & 64'h3FF_FFFF;
      q  = (w >> 2) & 64'hFF_FFFF;
      gb = w[1];
      sb = w[0] | s;
    end
    if (gb && (sb || q[0])) q = q + 1;
    if (under) return {sign, (q >= 64'h80_0000) ? 8'd1 : 8'd0, q[22:0]};
    if (q == 64'h100_0000) begin
      q = 64'h80_0000;
      e = e + 1;
    end
    if (e >= 255) return {sign, 31'h7F80_0000};
    return {sign, e[7:0], q[22:0]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_tests++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  task automatic next_cycle();
    @(negedge clk);
    cyc++;
  endtask

  task automatic record();
    logic [LANES-1:0][31:0] r;
    for (int l = 0; l < LANES; l++)
      r[l] = ref_lane(in_mask[l], in_is_nan[l], in_is_inf[l], in_sign[l], in_sum[l],
                      in_guard[l], in_round[l], in_sticky[l], in_exponent[l]);
    h_valid[cyc] = in_valid;
    h_thr[cyc]   = in_thread_idx;
    h_mask[cyc]  = in_mask;
    h_res[cyc]   = r;
    h_rb[cyc]    = rollback_en && rollback_mem;
    h_rbthr[cyc] = rollback_thread_idx;
    h_flush[cyc] = 1'b0;
  endtask

  task automatic idle();
    in_valid = 1'b0; in_thread_idx = '0; in_mask = '0; in_sum = '0;
    in_guard = '0; in_round = '0; in_sticky = '0; in_exponent = '0;
    in_sign = '0; in_is_inf = '0; in_is_nan = '0;
    rollback_en = 1'b0; rollback_mem = 1'b0; rollback_thread_idx = '0;
  endtask

  task automatic rand_lanes();
    for (int l = 0; l < LANES; l++) begin
      case ($urandom_range(0, 7))
        0: in_sum[l] = 25'($urandom);
        1: in_sum[l] = {1'b1, 24'($urandom)};
        2: in_sum[l] = 25'($urandom) >> $urandom_range(1, 24);
        3: in_sum[l] = 25'h1FF_FFFF;
        4: in_sum[l] = 25'h0;
        5: in_sum[l] = {2'b01, 23'($urandom)};
        6: in_sum[l] = 25'h7F_FFFF >> $urandom_range(0, 20);
        default: in_sum[l] = {1'b0, 24'($urandom)};
      endcase
      case ($urandom_range(0, 3))
        0: in_exponent[l] = 8'($urandom_range(0, 30));
        1: in_exponent[l] = 8'($urandom_range(240, 255));
        default: in_exponent[l] = 8'($urandom_range(0, 255));
      endcase
      in_guard[l]  = 1'($urandom);
      in_round[l]  = 1'($urandom);
      in_sticky[l] = 1'($urandom);
      in_sign[l]   = 1'($urandom);
      in_is_nan[l] = ($urandom_range(0, 31) == 0);
      in_is_inf[l] = ($urandom_range(0, 31) == 0);
    end
    in_mask = LANES'($urandom);
  endtask

  task automatic set_lane(input int l, input logic [24:0] s, input logic g, input logic r,
                          input logic st, input logic [7:0] e, input logic sg);
    in_sum[l] = s; in_guard[l] = g; in_round[l] = r; in_sticky[l] = st;
    in_exponent[l] = e; in_sign[l] = sg; in_is_nan[l] = 1'b0; in_is_inf[l] = 1'b0;
  endtask

  // Compare process: output seen now belongs to the beat issued two cycles ago.
  int chk_k;
  bit chk_ev;
  always @(negedge clk) begin
    #1;
    if (chk_on && cyc >= 2) begin
      chk_k  = cyc - 2;
      chk_ev = h_valid[chk_k] && !h_flush[chk_k]
               && !(h_rb[chk_k] && h_rbthr[chk_k] == h_thr[chk_k])
               && !(h_rb[chk_k + 1] && h_rbthr[chk_k + 1] == h_thr[chk_k]);
      n_tests++;
      if (out_valid !== chk_ev) begin
        n_fail++;
        $display("FAIL pipe_valid beat %0d: got %0b want %0b", chk_k, out_valid, chk_ev);
      end else if (chk_ev) begin
        n_tests++;
        if (out_thread_idx !== h_thr[chk_k]) begin
          n_fail++;
          $display("FAIL pipe_thread beat %0d: got %0d want %0d", chk_k, out_thread_idx, h_thr[chk_k]);
        end
        n_tests++;
        if (out_mask !== h_mask[chk_k]) begin
          n_fail++;
          $display("FAIL pipe_mask beat %0d: got %h want %h", chk_k, out_mask, h_mask[chk_k]);
        end
        n_tests++;
        if (out_result !== h_res[chk_k]) begin
          n_fail++;
          $display("FAIL pipe_result beat %0d: got %h want %h", chk_k, out_result, h_res[chk_k]);
        end
      end
    end
  end

  initial begin
    reset = 1'b1;
    idle();
    for (int i = 0; i < int'(MAXC); i++) begin
      h_valid[i] = 1'b0; h_flush[i] = 1'b0; h_rb[i] = 1'b0;
      h_thr[i] = '0; h_rbthr[i] = '0; h_mask[i] = '0; h_res[i] = '0;
    end

    // Pin the reference model with hand-computed values
    chk("model_one_plus_one", ref_lane(1, 0, 0, 0, 25'h100_0000, 0, 0, 0, 8'd127), 32'h4000_0000);
    chk("model_cancel",       ref_lane(1, 0, 0, 0, 25'h000_0001, 0, 0, 0, 8'd127), 32'h3400_0000);
    chk("model_ne_odd",       ref_lane(1, 0, 0, 0, 25'h080_0001, 1, 0, 0, 8'd127), 32'h3F80_0002);
    chk("model_ne_even",      ref_lane(1, 0, 0, 0, 25'h080_0000, 1, 0, 0, 8'd127), 32'h3F80_0000);
    chk("model_overflow",     ref_lane(1, 0, 0, 0, 25'h1FF_FFFF, 0, 0, 0, 8'd254), 32'h7F80_0000);
    chk("model_nan",          ref_lane(1, 1, 1, 1, 25'h080_0000, 0, 0, 0, 8'd100), 32'h7FFF_FFFF);
    chk("model_neg_inf",      ref_lane(1, 0, 1, 1, 25'h080_0000, 0, 0, 0, 8'd100), 32'hFF80_0000);
    chk("model_underflow",    ref_lane(1, 0, 0, 0, 25'h000_0001, 0, 0, 0, 8'd10),  UF_WANT);
    chk("model_zero_signed",  ref_lane(1, 0, 0, 1, 25'h000_0000, 0, 0, 1, 8'd50),  32'h0000_0000);
    chk("model_masked",       ref_lane(0, 1, 0, 0, 25'h080_0000, 0, 0, 0, 8'd100), 32'h0000_0000);

    chk_on = 1'b1;
    next_cycle(); record();
    next_cycle(); record();
    #2;
    chk("reset_valid",  {31'd0, out_valid}, 32'd0);
    chk("reset_thread", {30'd0, out_thread_idx}, 32'd0);
    chk("reset_mask",   {16'd0, out_mask}, 32'd0);
    chk("reset_result", {31'd0, out_result == '0}, 32'd1);
    reset = 1'b0;

    // Directed beat covering the called-out cases, one per lane
    next_cycle();
    rand_lanes();
    in_valid = 1'b1; in_thread_idx = 2'd0; in_mask = 16'hFEFF;
    set_lane(0, 25'h100_0000, 0, 0, 0, 8'd127, 0);
    set_lane(1, 25'h000_0001, 0, 0, 0, 8'd127, 0);
    set_lane(2, 25'h080_0001, 1, 0, 0, 8'd127, 0);
    set_lane(3, 25'h080_0000, 1, 0, 0, 8'd127, 0);
    set_lane(4, 25'h1FF_FFFF, 0, 0, 0, 8'd254, 0);
    in_is_nan[5] = 1'b1;
    set_lane(6, 25'h000_0001, 0, 0, 0, 8'd10, 0);
    set_lane(7, 25'h000_0000, 0, 0, 1, 8'd60, 1);
    record();
    next_cycle(); idle(); record();
    #2 chk("latency_not_early", {31'd0, out_valid}, 32'd0);
    next_cycle(); idle(); record();
    #2;
    chk("latency_two", {31'd0, out_valid}, 32'd1);
    chk("dut_one_plus_one", out_result[0], 32'h4000_0000);
    chk("dut_cancel",       out_result[1], 32'h3400_0000);
    chk("dut_ne_odd",       out_result[2], 32'h3F80_0002);
    chk("dut_ne_even",      out_result[3], 32'h3F80_0000);
    chk("dut_overflow",     out_result[4], 32'h7F80_0000);
    chk("dut_nan",          out_result[5], 32'h7FFF_FFFF);
    chk("dut_underflow",    out_result[6], UF_WANT);
    chk("dut_zero_signed",  out_result[7], 32'h0000_0000);
    chk("dut_masked_lane",  out_result[8], 32'h0000_0000);

    // Rollback of thread 2 while its beat sits in stage 1
    next_cycle(); rand_lanes(); in_valid = 1'b1; in_thread_idx = 2'd2; record();
    next_cycle(); rand_lanes(); in_valid = 1'b1; in_thread_idx = 2'd1;
    rollback_en = 1'b1; rollback_mem = 1'b1; rollback_thread_idx = 2'd2; record();
    next_cycle(); idle(); record();
    #2 chk("rollback_squash", {31'd0, out_valid}, 32'd0);
    next_cycle(); idle(); record();
    #2;
    chk("rollback_other_valid",  {31'd0, out_valid}, 32'd1);
    chk("rollback_other_thread", {30'd0, out_thread_idx}, 32'd1);

    // Non-memory rollback leaves the pipeline alone
    next_cycle(); rand_lanes(); in_valid = 1'b1; in_thread_idx = 2'd3; record();
    next_cycle(); idle(); rollback_en = 1'b1; rollback_thread_idx = 2'd3; record();
    next_cycle(); idle(); record();
    #2 chk("rollback_nonmem_pass", {31'd0, out_valid}, 32'd1);

    // Asynchronous reset with beats in flight
    next_cycle(); rand_lanes(); in_valid = 1'b1; in_thread_idx = 2'($urandom); record();
    next_cycle(); rand_lanes(); in_valid = 1'b1; in_thread_idx = 2'($urandom); record();
    #2;
    reset = 1'b1;
    h_flush[cyc] = 1'b1;
    h_flush[cyc - 1] = 1'b1;
    #1;
    chk("async_reset_valid",  {31'd0, out_valid}, 32'd0);
    chk("async_reset_result", {31'd0, out_result == '0}, 32'd1);
    next_cycle(); idle(); record();
    next_cycle(); idle(); record();
    #2 reset = 1'b0;

    // Randomized traffic with rollbacks
    for (int n = 0; n < 1500 && cyc < int'(MAXC) - 8; n++) begin
      next_cycle();
      rand_lanes();
      in_valid            = ($urandom_range(0, 3) != 0);
      in_thread_idx       = 2'($urandom);
      rollback_en         = ($urandom_range(0, 4) == 0);
      rollback_mem        = 1'($urandom);
      rollback_thread_idx = 2'($urandom);
      record();
    end

    for (int n = 0; n < 4; n++) begin
      next_cycle(); idle(); record();
    end
    #3;
    chk_on = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
